// File: rtl/router_fifo.sv
// Router output-port FIFO: 16 x 9-bit words ({header marker, byte}), registered read data,
// flush via soft_rst, and a packet-byte counter that loads from header bytes as they are read.
module router_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] dout
);

  localparam int WORD_W = DATA_W + 1;
  localparam int CNT_W  = 7;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [CNT_W-1:0]  pkt_cnt;

  logic              wr_ok;
  logic              rd_ok;
  logic [WORD_W-1:0] rd_word;
  logic [CNT_W-1:0]  hdr_len;

  // Handshake: wr_en/rd_en are requests; a write is accepted only when full is low and a read
  // only when empty is low (flags as seen before the edge). Rejected requests change nothing.
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  assign rd_word = mem[rd_ptr];
  // Header byte carries payload length in bits [7:2]; +1 accounts for the trailing parity byte.
  assign hdr_len = CNT_W'(rd_word[DATA_W-1:2]) + CNT_W'(1);

  // Storage is cleared by the hard reset only; a flush leaves old words in place.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (!soft_rst && wr_ok) begin
      mem[wr_ptr] <= {lfd_state, din};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || soft_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || soft_rst) begin
      count <= '0;
    end else begin
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // dout holds between accepted reads; no same-cycle write-to-read bypass.
  always_ff @(posedge clk) begin
    if (!rst || soft_rst) begin
      dout <= '0;
    end else if (rd_ok) begin
      dout <= rd_word[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || soft_rst) begin
      pkt_cnt <= '0;
    end else if (rd_ok) begin
      if (rd_word[DATA_W]) begin
        pkt_cnt <= hdr_len;
      end else if (pkt_cnt != '0) begin
        pkt_cnt <= pkt_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: queue scoreboard for read data, a small occupancy model
// for the flags, and hand-computed packet-counter values for the header case.
module tb_router_fifo;

  logic       clk;
  logic       rst;
  logic       soft_rst;
  logic       wr_en;
  logic       rd_en;
  logic       lfd_state;
  logic [7:0] din;
  logic       full;
  logic       empty;
  logic [7:0] dout;

  logic [7:0] exp_q[$];
  logic [7:0] last_dout;
  int         model_occ;
  int         n_checks;
  int         n_fail;

  router_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .soft_rst  (soft_rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .lfd_state (lfd_state),
    .din       (din),
    .full      (full),
    .empty     (empty),
    .dout      (dout)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs after a negedge, let the posedge act, sample at the next negedge.
  task automatic cycle(input logic w, input logic r, input logic lfd, input logic [7:0] d);
    logic wok;
    logic rok;
    wok = w && (model_occ < 16);
    rok = r && (model_occ > 0);
    wr_en = w;
    rd_en = r;
    lfd_state = lfd;
    din = d;
    @(negedge clk);
    if (rok) last_dout = exp_q.pop_front();
    if (wok) exp_q.push_back(d);
    model_occ = model_occ + (wok ? 1 : 0) - (rok ? 1 : 0);
    check("dout", dout, last_dout);
    check("empty", empty, model_occ == 0);
    check("full", full, model_occ == 16);
    wr_en = 1'b0;
    rd_en = 1'b0;
    lfd_state = 1'b0;
  endtask

  task automatic write_byte(input logic lfd, input logic [7:0] d);
    cycle(1'b1, 1'b0, lfd, d);
  endtask

  task automatic read_byte();
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic flush();
    soft_rst = 1'b1;
    wr_en = 1'b1;
    rd_en = 1'b1;
    din = 8'h5A;
    @(negedge clk);
    soft_rst = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    exp_q.delete();
    model_occ = 0;
    last_dout = 8'h00;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    model_occ = 0;
    last_dout = 8'h00;
    rst = 1'b0;
    soft_rst = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    lfd_state = 1'b0;
    din = 8'h00;

    // Reset
    @(negedge clk);
    rst = 1'b1;
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_dout", dout, 8'h00);
    check("rst_pkt_cnt", dut.pkt_cnt, 7'd0);

    // Fill with 15 random bytes (first is a header), then 16 reads
    for (int i = 0; i < 15; i++) begin
      write_byte(i == 0, 8'($urandom_range(0, 255)));
    end
    check("fill15_empty", empty, 1'b0);
    check("fill15_full", full, 1'b0);
    for (int i = 0; i < 16; i++) begin
      read_byte();
    end
    check("drain_empty", empty, 1'b1);

    // Full boundary: 16 writes, dropped 17th, 16 reads
    for (int i = 0; i < 16; i++) begin
      write_byte(1'b0, 8'(i));
    end
    check("full_set", full, 1'b1);
    write_byte(1'b0, 8'hAA);
    check("full_drop_count", dut.count, 5'd16);
    for (int i = 0; i < 16; i++) begin
      read_byte();
      check("full_order", dout, 8'(i));
    end

    // Wrap-around: 10 in/out, then 12 in/out
    for (int i = 0; i < 10; i++) write_byte(1'b0, 8'h30 + 8'(i));
    for (int i = 0; i < 10; i++) read_byte();
    for (int i = 0; i < 12; i++) write_byte(1'b0, 8'hC0 + 8'(i));
    for (int i = 0; i < 12; i++) read_byte();
    check("wrap_last", dout, 8'hCB);

    // Simultaneous read/write at occupancy 5
    for (int i = 0; i < 5; i++) write_byte(1'b0, 8'h50 + 8'(i));
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 8'h60 + 8'(i));
      check("simul_count", dut.count, 5'd5);
    end
    check("simul_dout", dout, 8'h53);
    for (int i = 0; i < 5; i++) read_byte();
    // Simultaneous on empty: only the write happens
    cycle(1'b1, 1'b1, 1'b0, 8'h77);
    check("simul_empty_count", dut.count, 5'd1);
    read_byte();
    check("simul_empty_dout", dout, 8'h77);

    // Soft reset after 6 writes
    for (int i = 0; i < 6; i++) write_byte(1'b0, 8'h90 + 8'(i));
    flush();
    check("soft_empty", empty, 1'b1);
    check("soft_full", full, 1'b0);
    check("soft_dout", dout, 8'h00);
    check("soft_count", dut.count, 5'd0);

    // Header load: 0x14 -> 5 + 1 = 6, then 5, 4, 3
    write_byte(1'b1, 8'h14);
    write_byte(1'b0, 8'h81);
    write_byte(1'b0, 8'h42);
    write_byte(1'b0, 8'h07);
    read_byte();
    check("hdr_load", dut.pkt_cnt, 7'd6);
    read_byte();
    check("hdr_dec1", dut.pkt_cnt, 7'd5);
    read_byte();
    check("hdr_dec2", dut.pkt_cnt, 7'd4);
    read_byte();
    check("hdr_dec3", dut.pkt_cnt, 7'd3);
    read_byte();
    check("hdr_empty_hold", dut.pkt_cnt, 7'd3);
    check("hdr_dout_hold", dout, 8'h07);

    // Hard reset mid-stream overrides a pending soft reset and writes
    write_byte(1'b0, 8'hEE);
    rst = 1'b0;
    soft_rst = 1'b1;
    wr_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    soft_rst = 1'b0;
    wr_en = 1'b0;
    exp_q.delete();
    model_occ = 0;
    last_dout = 8'h00;
    check("rst2_empty", empty, 1'b1);
    check("rst2_dout", dout, 8'h00);
    check("rst2_mem0", dut.mem[0], 9'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
